// File: rtl/burst_reorder_buffer.sv
// burst_reorder_buffer
//   Reorder buffer that hands out IDs in bursts of 1..MaxBurstLen consecutive
//   entries, accepts data beats out of order by ID and releases them strictly
//   in allocation order. Each entry carries a last marker set on the final
//   beat of its burst. All NumWords entries are usable (count-based full).
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   id_req_valid_i      request a burst of IDs
//   id_req_len_i        burst length minus one
//   id_req_ready_o      burst fits in the free entries (accepted this cycle)
//   id_o                base ID of the burst
//   push_valid_i        write one beat (no backpressure)
//   push_id_i           target entry of the beat
//   push_data_i         beat payload
//   data_o, last_o      head payload and its last marker
//   valid_o, ready_i    head handshake
//   free_cnt_o          number of unallocated entries
//   flush_i             synchronous flush
//
// Build option
//   BURST_ROB_FLUSH_EN  when defined, flush_i clears pointers, count and valid
//                       bits at the next edge. When undefined flush_i is
//                       ignored and should be tied to 0.

module burst_reorder_buffer #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumWords    = 8,
    parameter int unsigned MaxBurstLen = 4,
    parameter bit          FallThrough = 1'b0,
    parameter int unsigned IdWidth     = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned LenWidth    = (MaxBurstLen > 1) ? $clog2(MaxBurstLen) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 id_req_valid_i,
    input  logic [LenWidth-1:0]  id_req_len_i,
    output logic                 id_req_ready_o,
    output logic [IdWidth-1:0]   id_o,
    input  logic                 push_valid_i,
    input  logic [IdWidth-1:0]   push_id_i,
    input  logic [DataWidth-1:0] push_data_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 last_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [IdWidth:0]     free_cnt_o,
    input  logic                 flush_i
);

    typedef logic [IdWidth-1:0] id_t;
    typedef logic [IdWidth:0]   cnt_t;

    localparam cnt_t Depth = cnt_t'(NumWords);
    localparam id_t  LastIdx = id_t'(NumWords - 1);

    id_t  rd_ptr_q, wr_ptr_q;
    cnt_t cnt_q;

    logic [NumWords-1:0][DataWidth-1:0] mem_q;
    logic [NumWords-1:0]                valid_q;
    logic [NumWords-1:0]                last_q;

    logic flush;
`ifdef BURST_ROB_FLUSH_EN
    assign flush = flush_i;
`else
    logic flush_unused;
    assign flush        = 1'b0;
    assign flush_unused = flush_i;
`endif

    cnt_t free_cnt, len, wr_sum;
    id_t  wr_ptr_n, rd_ptr_n;
    logic alloc, push, pop, head_ft;

    // Capacity is judged on the registered count only, so a pop in the same
    // cycle never widens the burst that can be accepted.
    assign free_cnt       = Depth - cnt_q;
    assign free_cnt_o     = free_cnt;
    assign len            = cnt_t'(id_req_len_i) + cnt_t'(1);
    assign id_req_ready_o = !flush && (len <= free_cnt);
    assign alloc          = id_req_valid_i && id_req_ready_o;
    assign id_o           = wr_ptr_q;

    assign push = push_valid_i && !flush;

    // Fall-through: a beat landing on the head is presented immediately.
    assign head_ft = FallThrough && push && (push_id_i == rd_ptr_q);
    assign valid_o = !flush && (valid_q[rd_ptr_q] || head_ft);
    assign data_o  = head_ft ? push_data_i : mem_q[rd_ptr_q];
    assign last_o  = last_q[rd_ptr_q];
    assign pop     = valid_o && ready_i;

    // Non-power-of-two depth: wrap by compare-and-subtract.
    assign wr_sum   = cnt_t'(wr_ptr_q) + len;
    assign wr_ptr_n = (wr_sum >= Depth) ? id_t'(wr_sum - Depth) : id_t'(wr_sum);
    assign rd_ptr_n = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + id_t'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (alloc) wr_ptr_q <= wr_ptr_n;
            if (pop)   rd_ptr_q <= rd_ptr_n;
            cnt_q <= cnt_q + (alloc ? len : cnt_t'(0)) - cnt_t'(pop);
        end
    end

    for (genvar i = 0; i < NumWords; i++) begin : g_entry
        localparam id_t Idx = id_t'(i);

        cnt_t                 off;
        logic                 hit_alloc, hit_push, hit_pop;
        logic [DataWidth-1:0] mem_r;
        logic                 valid_r, last_r;

        // Distance of this entry from the allocation pointer, modulo depth.
        assign off = (Idx >= wr_ptr_q) ? cnt_t'(Idx) - cnt_t'(wr_ptr_q)
                                       : cnt_t'(Idx) + Depth - cnt_t'(wr_ptr_q);
        assign hit_alloc = alloc && (off < len);
        assign hit_push  = push && (push_id_i == Idx);
        assign hit_pop   = pop && (rd_ptr_q == Idx);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_r   <= '0;
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else if (flush) begin
                valid_r <= 1'b0;
            end else begin
                if (hit_push) mem_r <= push_data_i;
                // A fall-through beat popped in its own cycle never sets valid.
                if (hit_pop)       valid_r <= 1'b0;
                else if (hit_push) valid_r <= 1'b1;
                if (hit_alloc) last_r <= (off == len - cnt_t'(1));
            end
        end

        assign mem_q[i]   = mem_r;
        assign valid_q[i] = valid_r;
        assign last_q[i]  = last_r;
    end

`ifndef SYNTHESIS
    cnt_t push_off;
    assign push_off = (push_id_i >= rd_ptr_q) ? cnt_t'(push_id_i) - cnt_t'(rd_ptr_q)
                                              : cnt_t'(push_id_i) + Depth - cnt_t'(rd_ptr_q);

    a_push_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> ((32'(push_id_i) < NumWords) && (push_off < cnt_q) && !valid_q[push_id_i]));

    a_len_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        id_req_valid_i |-> (32'(id_req_len_i) < MaxBurstLen));
`endif

endmodule

// File: tb/tb_burst_reorder_buffer.sv
// Directed bench for burst_reorder_buffer: a default instance (8 deep),
// a 6-deep instance for non-power-of-two wrap, and a fall-through instance.
module tb_burst_reorder_buffer;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // default instance
    logic a_req_v, a_req_rdy, a_push_v, a_last, a_vld, a_rdy, a_flush;
    logic [1:0] a_len;
    logic [2:0] a_id, a_push_id;
    logic [31:0] a_push_d, a_data;
    logic [3:0] a_free;

    // 6-deep instance
    logic s_req_v, s_req_rdy, s_push_v, s_last, s_vld, s_rdy;
    logic [1:0] s_len;
    logic [2:0] s_id, s_push_id;
    logic [31:0] s_push_d, s_data;
    logic [3:0] s_free;

    // fall-through instance
    logic f_req_v, f_req_rdy, f_push_v, f_last, f_vld, f_rdy;
    logic [1:0] f_len;
    logic [2:0] f_id, f_push_id;
    logic [31:0] f_push_d, f_data;
    logic [3:0] f_free;

    burst_reorder_buffer #(.DataWidth(32), .NumWords(8), .MaxBurstLen(4), .FallThrough(1'b0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_req_valid_i(a_req_v), .id_req_len_i(a_len), .id_req_ready_o(a_req_rdy), .id_o(a_id),
        .push_valid_i(a_push_v), .push_id_i(a_push_id), .push_data_i(a_push_d),
        .data_o(a_data), .last_o(a_last), .valid_o(a_vld), .ready_i(a_rdy),
        .free_cnt_o(a_free), .flush_i(a_flush));

    burst_reorder_buffer #(.DataWidth(32), .NumWords(6), .MaxBurstLen(4), .FallThrough(1'b0)) dut6 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_req_valid_i(s_req_v), .id_req_len_i(s_len), .id_req_ready_o(s_req_rdy), .id_o(s_id),
        .push_valid_i(s_push_v), .push_id_i(s_push_id), .push_data_i(s_push_d),
        .data_o(s_data), .last_o(s_last), .valid_o(s_vld), .ready_i(s_rdy),
        .free_cnt_o(s_free), .flush_i(1'b0));

    burst_reorder_buffer #(.DataWidth(32), .NumWords(8), .MaxBurstLen(4), .FallThrough(1'b1)) dut_ft (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_req_valid_i(f_req_v), .id_req_len_i(f_len), .id_req_ready_o(f_req_rdy), .id_o(f_id),
        .push_valid_i(f_push_v), .push_id_i(f_push_id), .push_data_i(f_push_d),
        .data_o(f_data), .last_o(f_last), .valid_o(f_vld), .ready_i(f_rdy),
        .free_cnt_o(f_free), .flush_i(1'b0));

    task automatic test_reset;
        rst_ni = 1'b0;
        #3;
        chk_cnt++; if (a_vld !== 1'b0) $display("FAIL rst_valid got %0b want 0", a_vld); else pass_cnt++;
        chk_cnt++; if (a_last !== 1'b0) $display("FAIL rst_last got %0b want 0", a_last); else pass_cnt++;
        chk_cnt++; if (a_data !== 32'h0) $display("FAIL rst_data got %0h want 0", a_data); else pass_cnt++;
        chk_cnt++; if (a_id !== 3'd0) $display("FAIL rst_id got %0d want 0", a_id); else pass_cnt++;
        chk_cnt++; if (a_req_rdy !== 1'b1) $display("FAIL rst_ready got %0b want 1", a_req_rdy); else pass_cnt++;
        chk_cnt++; if (a_free !== 4'd8) $display("FAIL rst_free got %0d want 8", a_free); else pass_cnt++;
        chk_cnt++; if (s_free !== 4'd6) $display("FAIL rst_free6 got %0d want 6", s_free); else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_in_order;
        @(negedge clk_i); a_req_v = 1'b1; a_len = 2'd2; #1;
        chk_cnt++; if (a_id !== 3'd0) $display("FAIL inord_id0 got %0d want 0", a_id); else pass_cnt++;
        @(negedge clk_i); a_len = 2'd1; #1;
        chk_cnt++; if (a_id !== 3'd3) $display("FAIL inord_id1 got %0d want 3", a_id); else pass_cnt++;
        @(negedge clk_i); a_req_v = 1'b0; #1;
        chk_cnt++; if (a_free !== 4'd3) $display("FAIL inord_free got %0d want 3", a_free); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            a_push_v = 1'b1; a_push_id = 3'(k); a_push_d = 32'hA0 + 32'(k);
            @(negedge clk_i);
        end
        a_push_v = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_rdy = 1'b1; #1;
            chk_cnt++; if (a_vld !== 1'b1 || a_data !== 32'hA0 + 32'(k))
                $display("FAIL inord_pop%0d got v=%0b d=%0h want v=1 d=%0h", k, a_vld, a_data, 32'hA0 + 32'(k)); else pass_cnt++;
            chk_cnt++; if (a_last !== (k == 2 || k == 4))
                $display("FAIL inord_last%0d got %0b want %0b", k, a_last, (k == 2 || k == 4)); else pass_cnt++;
            @(negedge clk_i);
        end
        a_rdy = 1'b0; #1;
        chk_cnt++; if (a_vld !== 1'b0 || a_free !== 4'd8)
            $display("FAIL inord_empty got v=%0b free=%0d want v=0 free=8", a_vld, a_free); else pass_cnt++;
    endtask

    task automatic test_out_of_order;
        logic [2:0] ids [4];
        logic [31:0] dat [4];
        // rd/wr pointers sit at 5: burst covers 5,6,7,0; push offsets 3,1,2,0
        ids = '{3'd0, 3'd6, 3'd7, 3'd5};
        dat = '{32'hB3, 32'hB1, 32'hB2, 32'hB0};
        @(negedge clk_i); a_req_v = 1'b1; a_len = 2'd3; #1;
        chk_cnt++; if (a_id !== 3'd5) $display("FAIL ooo_id got %0d want 5", a_id); else pass_cnt++;
        @(negedge clk_i); a_req_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_push_v = 1'b1; a_push_id = ids[k]; a_push_d = dat[k]; #1;
            chk_cnt++; if (a_vld !== 1'b0) $display("FAIL ooo_wait%0d got %0b want 0", k, a_vld); else pass_cnt++;
            @(negedge clk_i);
        end
        a_push_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_rdy = 1'b1; #1;
            chk_cnt++; if (a_vld !== 1'b1 || a_data !== 32'hB0 + 32'(k) || a_last !== (k == 3))
                $display("FAIL ooo_pop%0d got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                         k, a_vld, a_data, a_last, 32'hB0 + 32'(k), (k == 3)); else pass_cnt++;
            @(negedge clk_i);
        end
        a_rdy = 1'b0;
    endtask

    task automatic test_full_wrap;
        for (int k = 0; k < 8; k++) begin
            a_req_v = 1'b1; a_len = 2'd0; #1;
            chk_cnt++; if (a_id !== 3'(k)) $display("FAIL full_id%0d got %0d want %0d", k, a_id, k); else pass_cnt++;
            @(negedge clk_i);
        end
        #1;
        chk_cnt++; if (a_free !== 4'd0 || a_req_rdy !== 1'b0)
            $display("FAIL full_state got free=%0d rdy=%0b want free=0 rdy=0", a_free, a_req_rdy); else pass_cnt++;
        a_push_v = 1'b1; a_push_id = 3'd0; a_push_d = 32'hC0;
        @(negedge clk_i); a_push_v = 1'b0; a_rdy = 1'b1; #1;
        chk_cnt++; if (a_vld !== 1'b1 || a_data !== 32'hC0 || a_req_rdy !== 1'b0)
            $display("FAIL full_pop got v=%0b d=%0h rdy=%0b want v=1 d=c0 rdy=0", a_vld, a_data, a_req_rdy); else pass_cnt++;
        @(negedge clk_i); a_rdy = 1'b0; #1;
        chk_cnt++; if (a_free !== 4'd1 || a_req_rdy !== 1'b1 || a_id !== 3'd0)
            $display("FAIL full_realloc got free=%0d rdy=%0b id=%0d want 1 1 0", a_free, a_req_rdy, a_id); else pass_cnt++;
        @(negedge clk_i); a_req_v = 1'b0; #1;
        chk_cnt++; if (a_free !== 4'd0) $display("FAIL full_refill got %0d want 0", a_free); else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        @(negedge clk_i); #2; rst_ni = 1'b0; #1;
        chk_cnt++; if (a_free !== 4'd8 || a_vld !== 1'b0 || a_id !== 3'd0)
            $display("FAIL midrst got free=%0d v=%0b id=%0d want 8 0 0", a_free, a_vld, a_id); else pass_cnt++;
        @(negedge clk_i); rst_ni = 1'b1;
    endtask

    task automatic test_alloc_pop;
        @(negedge clk_i); a_req_v = 1'b1; a_len = 2'd3; #1;
        chk_cnt++; if (a_id !== 3'd0) $display("FAIL ap_id0 got %0d want 0", a_id); else pass_cnt++;
        @(negedge clk_i); a_len = 2'd0; #1;
        chk_cnt++; if (a_id !== 3'd4) $display("FAIL ap_id1 got %0d want 4", a_id); else pass_cnt++;
        @(negedge clk_i); a_req_v = 1'b0; a_push_v = 1'b1; a_push_id = 3'd0; a_push_d = 32'hE0; #1;
        chk_cnt++; if (a_free !== 4'd3) $display("FAIL ap_free5 got %0d want 3", a_free); else pass_cnt++;
        @(negedge clk_i); a_push_v = 1'b0; a_rdy = 1'b1; a_req_v = 1'b1; a_len = 2'd1; #1;
        chk_cnt++; if (a_vld !== 1'b1 || a_req_rdy !== 1'b1 || a_data !== 32'hE0)
            $display("FAIL ap_both got v=%0b rdy=%0b d=%0h want 1 1 e0", a_vld, a_req_rdy, a_data); else pass_cnt++;
        @(negedge clk_i); a_req_v = 1'b0; a_rdy = 1'b0; #1;
        chk_cnt++; if (a_free !== 4'd2) $display("FAIL ap_free got %0d want 2", a_free); else pass_cnt++;
        a_len = 2'd1; #1;
        chk_cnt++; if (a_req_rdy !== 1'b1) $display("FAIL ap_fit got %0b want 1", a_req_rdy); else pass_cnt++;
        a_len = 2'd2; #1;
        chk_cnt++; if (a_req_rdy !== 1'b0) $display("FAIL ap_nofit got %0b want 0", a_req_rdy); else pass_cnt++;
    endtask

`ifdef BURST_ROB_FLUSH_EN
    task automatic test_flush;
        @(negedge clk_i); a_push_v = 1'b1; a_push_id = 3'd1; a_push_d = 32'hF1;
        @(negedge clk_i); a_push_v = 1'b0; #1;
        chk_cnt++; if (a_vld !== 1'b1) $display("FAIL fl_pre got %0b want 1", a_vld); else pass_cnt++;
        a_flush = 1'b1; a_push_v = 1'b1; a_push_id = 3'd2; a_push_d = 32'hF2; a_rdy = 1'b1; #1;
        chk_cnt++; if (a_vld !== 1'b0 || a_req_rdy !== 1'b0)
            $display("FAIL fl_during got v=%0b rdy=%0b want 0 0", a_vld, a_req_rdy); else pass_cnt++;
        @(negedge clk_i); a_flush = 1'b0; a_push_v = 1'b0; a_rdy = 1'b0; #1;
        chk_cnt++; if (a_vld !== 1'b0 || a_free !== 4'd8 || a_id !== 3'd0)
            $display("FAIL fl_after got v=%0b free=%0d id=%0d want 0 8 0", a_vld, a_free, a_id); else pass_cnt++;
    endtask
`endif

    task automatic test_wrap6;
        logic [2:0] ord [6];
        logic       lst [6];
        ord = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        lst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk_i); s_req_v = 1'b1; s_len = 2'd1; #1;
        chk_cnt++; if (s_id !== 3'd0) $display("FAIL w6_id0 got %0d want 0", s_id); else pass_cnt++;
        @(negedge clk_i); #1;
        chk_cnt++; if (s_id !== 3'd2) $display("FAIL w6_id1 got %0d want 2", s_id); else pass_cnt++;
        @(negedge clk_i); s_req_v = 1'b0; s_push_v = 1'b1; s_push_id = 3'd0; s_push_d = 32'h60;
        @(negedge clk_i); s_push_id = 3'd1; s_push_d = 32'h61;
        @(negedge clk_i); s_push_v = 1'b0; s_rdy = 1'b1; #1;
        chk_cnt++; if (s_vld !== 1'b1 || s_data !== 32'h60) $display("FAIL w6_pop0 got v=%0b d=%0h want 1 60", s_vld, s_data); else pass_cnt++;
        @(negedge clk_i); #1;
        chk_cnt++; if (s_vld !== 1'b1 || s_data !== 32'h61) $display("FAIL w6_pop1 got v=%0b d=%0h want 1 61", s_vld, s_data); else pass_cnt++;
        @(negedge clk_i); s_rdy = 1'b0; s_req_v = 1'b1; s_len = 2'd2; #1;
        chk_cnt++; if (s_free !== 4'd4 || s_id !== 3'd4) $display("FAIL w6_wrapid got free=%0d id=%0d want 4 4", s_free, s_id); else pass_cnt++;
        @(negedge clk_i); s_len = 2'd0; #1;
        chk_cnt++; if (s_id !== 3'd1) $display("FAIL w6_nextid got %0d want 1", s_id); else pass_cnt++;
        @(negedge clk_i); s_req_v = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_push_v = 1'b1; s_push_id = ord[k]; s_push_d = 32'h60 + 32'(ord[k]);
            @(negedge clk_i);
        end
        s_push_v = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_rdy = 1'b1; #1;
            chk_cnt++; if (s_vld !== 1'b1 || s_data !== 32'h60 + 32'(ord[k]) || s_last !== lst[k])
                $display("FAIL w6_drain%0d got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                         k, s_vld, s_data, s_last, 32'h60 + 32'(ord[k]), lst[k]); else pass_cnt++;
            @(negedge clk_i);
        end
        s_rdy = 1'b0; #1;
        chk_cnt++; if (s_free !== 4'd6) $display("FAIL w6_free got %0d want 6", s_free); else pass_cnt++;
    endtask

    task automatic test_fall_through;
        @(negedge clk_i); f_req_v = 1'b1; f_len = 2'd0; #1;
        chk_cnt++; if (f_id !== 3'd0) $display("FAIL ft_id got %0d want 0", f_id); else pass_cnt++;
        @(negedge clk_i); f_req_v = 1'b0; f_push_v = 1'b1; f_push_id = 3'd0; f_push_d = 32'hD0; f_rdy = 1'b1; #1;
        chk_cnt++; if (f_vld !== 1'b1 || f_data !== 32'hD0) $display("FAIL ft_same got v=%0b d=%0h want 1 d0", f_vld, f_data); else pass_cnt++;
        @(negedge clk_i); f_push_v = 1'b0; #1;
        chk_cnt++; if (f_vld !== 1'b0 || f_free !== 4'd8) $display("FAIL ft_gone got v=%0b free=%0d want 0 8", f_vld, f_free); else pass_cnt++;
        f_rdy = 1'b0; f_req_v = 1'b1;
        @(negedge clk_i); f_req_v = 1'b0; f_push_v = 1'b1; f_push_id = 3'd1; f_push_d = 32'hD1; #1;
        chk_cnt++; if (f_vld !== 1'b1 || f_data !== 32'hD1) $display("FAIL ft_hold0 got v=%0b d=%0h want 1 d1", f_vld, f_data); else pass_cnt++;
        @(negedge clk_i); f_push_v = 1'b0; #1;
        chk_cnt++; if (f_vld !== 1'b1 || f_data !== 32'hD1 || f_last !== 1'b1)
            $display("FAIL ft_hold1 got v=%0b d=%0h l=%0b want 1 d1 1", f_vld, f_data, f_last); else pass_cnt++;
        f_rdy = 1'b1;
        @(negedge clk_i); f_rdy = 1'b0; #1;
        chk_cnt++; if (f_vld !== 1'b0) $display("FAIL ft_popped got %0b want 0", f_vld); else pass_cnt++;
    endtask

    initial begin
        a_req_v = 0; a_len = 0; a_push_v = 0; a_push_id = 0; a_push_d = 0; a_rdy = 0; a_flush = 0;
        s_req_v = 0; s_len = 0; s_push_v = 0; s_push_id = 0; s_push_d = 0; s_rdy = 0;
        f_req_v = 0; f_len = 0; f_push_v = 0; f_push_id = 0; f_push_d = 0; f_rdy = 0;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_mid_reset();
        test_full_wrap();
        test_mid_reset();
        test_alloc_pop();
`ifdef BURST_ROB_FLUSH_EN
        test_flush();
`endif
        test_wrap6();
        test_fall_through();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/burst_reorder_buffer.md
# burst_reorder_buffer

Reorder buffer that allocates IDs in bursts of 1..MaxBurstLen consecutive entries per request. Accepts out-of-order writes by ID and releases data strictly in allocation order through a valid/ready output, with a per-entry last marker. Sits between a multi-beat requester (e.g. a core or DMA issuing burst loads) and an out-of-order response network, and is the burst-capable, full-capacity successor of the single-ID ROB.

## Interface
- DataWidth, 32, payload width in bits
- NumWords, 8, ROB depth; any value ≥1, need not be a power of two
- MaxBurstLen, 4, largest burst per request; 1 ≤ MaxBurstLen ≤ NumWords
- FallThrough, 0, 1 = a write to the head entry is visible at the output in the same cycle
- IdWidth, derived, idx_width(NumWords)
- LenWidth, derived, idx_width(MaxBurstLen)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- id_req_valid_i  in  1  request a burst of IDs
- id_req_len_i  in  LenWidth  burst length minus one
- id_req_ready_o  out  1  burst accepted this cycle
- id_o  out  IdWidth  base ID of the burst
- push_valid_i  in  1  write one data beat
- push_id_i  in  IdWidth  target entry
- push_data_i  in  DataWidth  beat payload
- data_o  out  DataWidth  head payload
- last_o  out  1  head beat is the final beat of its burst
- valid_o  out  1  head entry holds data
- ready_i  in  1  consumer takes the head
- free_cnt_o  out  IdWidth+1  unallocated entries
- flush_i  in  1  synchronous flush; functional only with the macro below

## Operation
- State: rd_ptr_q, wr_ptr_q (IdWidth bits), cnt_q (IdWidth+1 bits, 0..NumWords), and per entry mem, valid and last bits.
- Full capacity: all NumWords entries are usable. free_cnt_o = NumWords − cnt_q.
- Allocation: len = id_req_len_i + 1. id_req_ready_o = (len ≤ free_cnt_o). The burst is accepted when id_req_valid_i && id_req_ready_o.
- Accepted burst: id_o = wr_ptr_q. Entries wr_ptr_q .. wr_ptr_q+len−1 (mod NumWords) get last=0, except the final entry, which gets last=1. wr_ptr advances by len mod NumWords; the wrap uses compare-and-subtract, not bit truncation.
- Push: when push_valid_i, write mem[push_id_i] and set valid=1. There is no backpressure. A push to an unallocated or already-valid entry is illegal and flagged by a simulation assertion.
- Output: data_o, last_o and valid_o come from the entry at rd_ptr_q.
- FallThrough=1: if push_id_i == rd_ptr_q, the output shows the pushed data in the same cycle. If it is also popped that cycle, valid stays 0.
- Pop: when valid_o && ready_i, clear the head's valid bit, advance rd_ptr_q with wrap, and decrement cnt.
- Allocation and pop in the same cycle: cnt_n = cnt_q + len − 1.
- Capacity uses the registered count, so a same-cycle pop does not enlarge the burst that can be accepted.
- Illegal inputs, each flagged by an assertion: id_req_len_i ≥ MaxBurstLen; ready_i while !valid_o is harmless and ignored.

## Timing
- Reset values: valid_o=0, last_o=0, data_o=0, id_o=0, id_req_ready_o=1, free_cnt_o=NumWords. All pointers, counters, valid, last and mem bits clear.
- id_req_ready_o and id_o are combinational from registered state and id_req_len_i.
- Push → valid_o: 1 cycle with FallThrough=0, 0 cycles with FallThrough=1 when the push targets the head.
- Pop → next head visible: the next cycle.
- Allocation → free_cnt_o update: the next cycle.
- Throughput: one pop per cycle, one push per cycle, one burst allocation per cycle.
- Reset asserted mid-operation returns everything to reset state immediately. Buffered data is lost.

## Configuration
- BURST_ROB_FLUSH_EN defined: flush_i=1 clears pointers, cnt and all valid bits at the next edge.
  - During the flush cycle: id_req_ready_o=0 and valid_o=0, and any push or pop is ignored.
  - After the flush: free_cnt_o=NumWords and id_o=0.
- Not defined: flush_i is ignored and no flush logic is synthesised. Tie the port to 0.

## Test plan
- In-order bursts: after reset, request len 3 then len 2 (NumWords=8) → id_o=0, then 3; free_cnt_o=3. Push IDs 0..4 in order → pop sequence 0..4 with last_o=1 on IDs 2 and 4.
- Out-of-order fill: allocate 4, push IDs 3,1,2,0 → valid_o stays 0 until ID 0 is written, then 4 consecutive pops with last only on ID 3.
- Full and wrap: allocate 8 singles → free_cnt_o=0 and id_req_ready_o=0 for a len-1 request. Pop one → next cycle a len-1 request is accepted with id_o=0. With NumWords=6 and wr_ptr=4, a len-3 burst yields IDs 4,5,0.
- Simultaneous allocate and pop: cnt=5, pop the head and allocate len 2 in the same cycle → free_cnt_o goes from 3 to 2.
- FallThrough=1: push to the head with ready_i=1 → data_o equals the pushed data in the same cycle, and the entry does not reappear next cycle.
- Flush (macro on): 3 entries pending, assert flush_i → next cycle valid_o=0, free_cnt_o=8, id_o=0.
